// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
//
// Bundles the parallel-side handshake and the serial-side strobes of the
// parallel-in / serial-out stage so that the serializer and whatever drives
// it share a single port.
//
// Parameters
//   WIDTH  - parallel word length in bits (equals the downstream sipo WIDTH)
//   GAP_W  - width of the inter-bit gap field
//
// Signals
//   in_valid  - producer has a word on in_data
//   in_ready  - serializer can accept a word this cycle
//   in_data   - parallel word, bit WIDTH-1 is sent first
//   gap       - idle cycles between consecutive bit strobes of one word
//   load      - one-cycle bit strobe to the downstream sipo
//   data_out  - serial bit, meaningful only while load=1 (0 otherwise)
//   busy      - a word is in progress (acceptance .. last load)
//   done      - one-cycle pulse in the cycle after the last load of a word
//
// Modports
//   master - the word producer (drives in_valid/in_data/gap)
//   slave  - the serializer itself
// ---------------------------------------------------------------------------
interface piso_serializer_if #(
    parameter int WIDTH = 42,
    parameter int GAP_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [GAP_W-1:0] gap;
    logic             load;
    logic             data_out;
    logic             busy;
    logic             done;

    modport master (
        output in_valid,
        output in_data,
        output gap,
        input  in_ready,
        input  load,
        input  data_out,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  gap,
        output in_ready,
        output load,
        output data_out,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out stage feeding a sipo shift register. A WIDTH-bit
// word is accepted over a valid/ready handshake and emitted MSB first as
// single-cycle load/data_out strobes. A gap of idle cycles, latched with the
// word, is inserted between consecutive bit strobes to model slow links.
//
// Ports
//   clk   - system clock, rising edge
//   rst   - asynchronous reset, active high
//   bus   - piso_serializer_if.slave:
//             in_valid/in_ready/in_data/gap  (parallel side)
//             load/data_out                  (serial strobes)
//             busy/done                      (status)
//
// Timing summary
//   accept at edge N  -> first load in cycle N+1
//   load spacing      -> gap_q+1 cycles
//   done              -> cycle after the last load, in_ready already high
//   every output is a flop; nothing combinational from in_valid to in_ready
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH = 42,
    parameter int GAP_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    piso_serializer_if.slave    bus
);

    // Bit counter only ever holds WIDTH-1 .. 0.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   shift_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt_q;

    logic               load_q;
    logic               data_out_q;
    logic               busy_q;
    logic               done_q;
    logic               in_ready_q;

    logic               accept;

    // in_ready_q is a flop, so the handshake never loops back combinationally.
    assign accept = bus.in_valid && in_ready_q;

    // Shift register contents after one left shift; its MSB is the next bit
    // to go out when the following strobe comes without a gap.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shift_d[gi] = 1'b0;
            end else begin : g_upper
                assign shift_d[gi] = shift_q[gi-1];
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs. Output flops are loaded with the
    // value they must show in the state being entered, so load/data_out line
    // up exactly with SHIFT cycles and done lands on the first IDLE cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            load_q     <= 1'b0;
            data_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            // done is a single-cycle pulse unless re-armed below.
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= SHIFT;
                        shift_q    <= bus.in_data;
                        gap_q      <= bus.gap;
                        bit_cnt_q  <= CNT_W'(WIDTH - 1);
                        gap_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        load_q     <= 1'b1;
                        data_out_q <= bus.in_data[WIDTH-1];
                    end
                end

                SHIFT: begin
                    if (bit_cnt_q == '0) begin
                        // Last bit just went out.
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        load_q     <= 1'b0;
                        data_out_q <= 1'b0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                        shift_q   <= shift_d;
                        if (gap_q != '0) begin
                            state_q    <= GAP;
                            gap_cnt_q  <= gap_q;
                            load_q     <= 1'b0;
                            data_out_q <= 1'b0;
                        end else begin
                            // Back-to-back strobe: next bit is the MSB of
                            // the shifted register.
                            load_q     <= 1'b1;
                            data_out_q <= shift_d[WIDTH-1];
                        end
                    end
                end

                GAP: begin
                    // Counter runs gap_q..1, giving exactly gap_q idle cycles.
                    if (gap_cnt_q == GAP_W'(1)) begin
                        state_q    <= SHIFT;
                        gap_cnt_q  <= '0;
                        load_q     <= 1'b1;
                        data_out_q <= shift_q[WIDTH-1];
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean idle state.
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    load_q     <= 1'b0;
                    data_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.load     = load_q;
    assign bus.data_out = data_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//
// Drives piso_serializer through its interface and compares every output on
// every cycle against a timeline model: each accepted word is described only
// by its start cycle, gap and data, and the expected load/data_out/busy/done/
// in_ready values are computed from that with plain arithmetic. A small
// downstream sipo model reassembles the serial stream and checks each word.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_piso_serializer;

    localparam int W  = 42;
    localparam int GW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    piso_serializer_if #(.WIDTH(W), .GAP_W(GW)) bus ();

    piso_serializer #(.WIDTH(W), .GAP_W(GW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checker
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    // Cycle t is the clock period that follows the t-th rising edge.
    int             cyc     = 0;
    int             m_start = -10;
    int             m_last  = -10;
    int             m_gap   = 0;
    int             done_at = -10;
    logic [W-1:0]   m_word  = '0;
    logic [W-1:0]   exp_q[$];
    int             n_sent  = 0;
    int             n_abort = 0;
    int             n_seen  = 0;

    function automatic bit m_in_word(input int t);
        return (t >= m_start) && (t <= m_last);
    endfunction

    function automatic bit m_load(input int t);
        if (!m_in_word(t)) return 1'b0;
        return ((t - m_start) % (m_gap + 1)) == 0;
    endfunction

    function automatic bit m_data(input int t);
        int idx;
        if (!m_load(t)) return 1'b0;
        idx = (t - m_start) / (m_gap + 1);
        return m_word[W-1-idx];
    endfunction

    // Acceptance: in_valid seen at the edge while the model says ready in the
    // cycle that edge closes.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && bus.in_valid && !m_in_word(cyc - 1)) begin
            m_start = cyc;
            m_gap   = int'(bus.gap);
            m_word  = bus.in_data;
            m_last  = cyc + (W - 1) * (m_gap + 1);
            done_at = m_last + 1;
            exp_q.push_back(bus.in_data);
        end
    end

    // Reset aborts whatever word is in flight; nothing of it is delivered.
    logic [W-1:0] sipo_sr  = '0;
    int           sipo_cnt = 0;

    always @(posedge rst) begin
        m_start  = -10;
        m_last   = -10;
        done_at  = -10;
        sipo_cnt = 0;
        exp_q.delete();
    end

    // Per-cycle comparison plus downstream sipo, on the falling edge.
    always @(negedge clk) begin
        logic e_load, e_data, e_busy, e_done, e_rdy;
        if (rst) begin
            e_load = 1'b0; e_data = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
        end else begin
            e_load = m_load(cyc);
            e_data = m_data(cyc);
            e_busy = m_in_word(cyc);
            e_done = (cyc == done_at);
            e_rdy  = !m_in_word(cyc);
        end
        chk("load",     bus.load,     e_load);
        chk("data_out", bus.data_out, e_data);
        chk("busy",     bus.busy,     e_busy);
        chk("done",     bus.done,     e_done);
        chk("in_ready", bus.in_ready, e_rdy);

        if (!rst && bus.load) begin
            sipo_sr  = {sipo_sr[W-2:0], bus.data_out};
            sipo_cnt = sipo_cnt + 1;
            if (sipo_cnt == W) begin
                sipo_cnt = 0;
                n_seen++;
                if (exp_q.size() == 0) begin
                    chk("sipo_extra_word", 64'(sipo_sr), 64'h0);
                end else begin
                    $display("sipo word=%011h expected=%011h", sipo_sr, exp_q[0]);
                    chk("sipo_word", 64'(sipo_sr), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    // Tasks start and end just after a falling edge. send() leaves in_valid
    // high; the caller decides whether to drop it.
    task automatic send(input logic [W-1:0] w, input logic [GW-1:0] g);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        bus.gap      = g;
        n = 0;
        while (!bus.in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            chk("accept_timeout", 64'(bus.in_ready), 64'h1);
        end else begin
            @(negedge clk);
            n_sent++;
            $display("send word=%011h gap=%0d", w, g);
            // A changed gap must not affect the word already accepted.
            bus.gap = GW'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(bus.in_ready && !bus.busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", 64'(bus.in_ready), 64'h1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [63:0] r;
        int          nl;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.gap      = '0;

        // 1: reset with random inputs, then quiet idle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            r            = {$urandom, $urandom};
            bus.in_valid = 1'($urandom);
            bus.in_data  = r[W-1:0];
            bus.gap      = GW'($urandom);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);

        // 2: alternating pattern, no gap.
        send(42'h2AA_AAAA_AAAA, 5'd0);
        bus.in_valid = 1'b0;
        wait_idle();

        // 3: single set LSB, gap 3.
        send(42'h000_0000_0001, 5'd3);
        bus.in_valid = 1'b0;
        wait_idle();

        // 4: second word presented mid-word with a different gap.
        send(42'h0AB_CDEF_0123, 5'd2);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        send(42'h3FF_FFFF_FFFF, 5'd7);
        bus.in_valid = 1'b0;
        wait_idle();

        // 5: back-to-back with in_valid held high.
        send(42'h155_5555_5555, 5'd1);
        send(42'h0F0_F0F0_F0F0, 5'd1);
        bus.in_valid = 1'b0;
        wait_idle();

        // 6: asynchronous reset after the 10th load.
        send(42'h2C3_A5A5_0F0F, 5'd0);
        bus.in_valid = 1'b0;
        nl = 1;  // the first load is already on the bus
        for (int i = 0; i < 200 && nl < 10; i++) begin
            @(negedge clk);
            if (bus.load) nl++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        n_abort++;
        #1;
        chk("rst_load", 64'(bus.load), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_done", 64'(bus.done), 64'h0);
        chk("rst_rdy",  64'(bus.in_ready), 64'h1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(42'h3FF_0000_0001, 5'd0);
        bus.in_valid = 1'b0;
        wait_idle();

        // Random words, random gaps, sometimes back-to-back.
        for (int i = 0; i < 8; i++) begin
            r = {$urandom, $urandom};
            send(r[W-1:0], (i == 3) ? 5'd31 : GW'($urandom_range(0, 4)));
            if ($urandom_range(0, 1) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        wait_idle();

        chk("words_pending", 64'(exp_q.size()), 64'h0);
        chk("words_seen", 64'(n_seen), 64'(n_sent - n_abort));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out stage that sits directly upstream of the sipo shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB first as single-cycle load/data strobes.
- These strobes match the sipo's load/data_in input.
- A programmable gap of idle cycles between bit strobes models slow or irregular serial links.

Parameters:
- WIDTH, 42, word length in bits; must equal the downstream sipo WIDTH.
- GAP_W, 5, width of the gap input; maximum gap is 2^GAP_W-1 cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active high.
- in_valid  input  1  parallel word present on in_data.
- in_ready  output  1  high when a word can be accepted.
- in_data  input  WIDTH  parallel word; bit WIDTH-1 is sent first.
- gap  input  GAP_W  idle cycles inserted between consecutive bit strobes of one word.
- load  output  1  bit strobe to downstream; one cycle per bit.
- data_out  output  1  serial bit; valid only while load=1.
- busy  output  1  word in progress (from acceptance until the last load cycle).
- done  output  1  one-cycle pulse in the cycle after the last load of a word.

Behaviour:
- Reset (async, immediate):
  - load=0, data_out=0, busy=0, done=0, in_ready=1.
  - State=IDLE; shift register, bit counter and gap counter cleared.
- States: IDLE, SHIFT, GAP. All outputs are registered or decoded from registered state. No combinational path from in_valid to in_ready.
- in_ready = (state==IDLE), including the done cycle.
- IDLE, on in_valid && in_ready at edge N:
  - Capture in_data into the shift register and gap into gap_q.
  - Set bit counter = WIDTH-1 and busy=1.
  - Go to SHIFT.
  - in_valid while in_ready=0 is ignored, with no capture and no side effects.
- SHIFT (exactly one cycle):
  - load=1, data_out = current MSB of the shift register.
  - Next edge:
    - If bit counter==0: go to IDLE with done=1 and busy=0.
    - Else: decrement the counter, shift left by one, then go to GAP if gap_q!=0 (loading the gap counter with gap_q), else stay in SHIFT.
- GAP:
  - load=0, data_out=0.
  - Decrement the gap counter each cycle; go to SHIFT when it reaches 1, so exactly gap_q idle cycles occur.
- Latency and timing:
  - First load is in cycle N+1 after the accept edge.
  - Consecutive loads are spaced gap_q+1 cycles apart.
  - A word occupies WIDTH + (WIDTH-1)*gap_q cycles from first to last load inclusive.
  - done is asserted in cycle last_load+1.
- gap_q is latched at acceptance. Changes on gap during a word have no effect until the next word.
- gap=0 gives WIDTH consecutive load cycles.
- Back-to-back words:
  - A word presented in the done cycle is accepted at the end of that cycle.
  - Its first load comes 2 cycles after the previous word's last load.
  - The minimum inter-word idle time is 1 cycle, independent of gap_q.
- data_out is forced to 0 whenever load=0.
- Reset asserted mid-word: outputs clear immediately and the partial word is discarded. There is no done pulse for the aborted word.
- Reset released: the next accepted word starts from its bit WIDTH-1.

Test Plan:
1. Assert rst with random inputs → load=0, data_out=0, busy=0, done=0, in_ready=1. Deassert rst; hold in_valid=0 for 20 cycles → outputs unchanged.
2. gap=0, in_data=42'h2AA_AAAA_AAAA, one-cycle in_valid:
   - load=1 for 42 consecutive cycles starting the cycle after accept.
   - data_out sequence starts 1,0,1,0,...
   - done pulses once in the cycle after the last load.
   - Downstream sipo data_out == 42'h2AA_AAAA_AAAA.
3. gap=3, in_data=42'h000_0000_0001:
   - load pulses exactly 4 cycles apart, 42 pulses spanning 165 cycles.
   - data_out=1 only on the 42nd pulse.
   - busy high throughout, in_ready low throughout.
4. gap=2 at accept, then change gap to 7 and assert in_valid with 42'h3FF_FFFF_FFFF mid-word:
   - Spacing stays 3 cycles.
   - The second word is not captured until in_ready returns.
   - The first word is delivered intact.
5. in_valid held high with words A=42'h155_5555_5555 then B=42'h0F0_F0F0_F0F0, gap=1:
   - B is accepted in A's done cycle.
   - B's first load comes 2 cycles after A's last load.
   - The sipo captures A, then B.
6. gap=0, assert rst asynchronously mid-cycle after the 10th load:
   - load and busy drop immediately; no done pulse occurs.
   - After release, word 42'h3FF_0000_0001 serializes fully starting at bit 41.
   - The sipo count resync is done by the bench.
